// File: rtl/mem_access_fsm_pkg.sv
// Shared constants, state encoding and strobe bundle for the load/store sequencer.
// Field positions follow the 16-bit instruction layout: opcode, mode, data sel, address sel.
package mem_access_fsm_pkg;

  localparam logic [3:0] OP_LOAD      = 4'h4;
  localparam logic [3:0] OP_STORE     = 4'h5;
  localparam logic [3:0] MODE_PLAIN   = 4'h0;
  localparam logic [3:0] MODE_POSTINC = 4'h1;

  localparam int FIELD_W  = 4;
  localparam int OPC_LSB  = 12;
  localparam int MODE_LSB = 8;
  localparam int DSEL_LSB = 4;
  localparam int ASEL_LSB = 0;

  // Select field: bit 3 picks the bank (0 = G, 1 = P), bits 2:0 the index.
  localparam int SEL_BANK_BIT = 3;
  localparam int SEL_IDX_W    = 3;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_DATA     = 4'd2,
    S_REQ      = 4'd3,
    S_WAIT_MFC = 4'd4,
    S_READ     = 4'd5,
    S_XFER     = 4'd6,
    S_INC      = 4'd7,
    S_DONE     = 4'd8,
    S_ERR      = 4'd9
  } state_e;

  typedef struct packed {
    logic busy;
    logic pc_inc;
    logic mar_en;
    logic mem_en;
    logic mem_rw;
    logic mdr_en_read;
    logic mdr_en_write;
    logic mdr_out;
    logic addr_inc;
    logic done;
    logic err;
  } strobe_t;

  function automatic logic [FIELD_W-1:0] field(input logic [15:0] instr, input int lsb);
    return instr[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/mem_access_fsm_if.sv
// Instruction handshake and datapath strobe bundle between a controller (master)
// and the sequencer (slave).
interface mem_access_fsm_if #(
  parameter int NUM_G = 4,
  parameter int NUM_P = 1
);

  logic             start;
  logic [15:0]      instr;
  logic             MFC;
  logic             busy;
  logic             PC_inc;
  logic             MAR_EN;
  logic             mem_EN;
  logic             mem_RW;
  logic             MDR_EN_read;
  logic             MDR_EN_write;
  logic             MDR_out;
  logic             addr_inc;
  logic [NUM_G-1:0] G_in;
  logic [NUM_G-1:0] G_out;
  logic [NUM_P-1:0] P_in;
  logic [NUM_P-1:0] P_out;
  logic             done;
  logic             err;

  modport master (
    output start, instr, MFC,
    input  busy, PC_inc, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_EN_write,
           MDR_out, addr_inc, G_in, G_out, P_in, P_out, done, err
  );

  modport slave (
    input  start, instr, MFC,
    output busy, PC_inc, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_EN_write,
           MDR_out, addr_inc, G_in, G_out, P_in, P_out, done, err
  );

endinterface

// File: rtl/mem_access_fsm_reg_sel_decode.sv
// Turns a 4-bit register select plus load/drive enables into one-hot G/P vectors,
// flagging selects that point past the implemented register count.
module reg_sel_decode
  import mem_access_fsm_pkg::*;
#(
  parameter int NUM_G = 4,
  parameter int NUM_P = 1
) (
  input  logic [FIELD_W-1:0] i_sel,
  input  logic               i_in_en,
  input  logic               i_out_en,
  output logic [NUM_G-1:0]   o_g_in,
  output logic [NUM_G-1:0]   o_g_out,
  output logic [NUM_P-1:0]   o_p_in,
  output logic [NUM_P-1:0]   o_p_out,
  output logic               o_legal
);

  logic                 w_is_p;
  logic [SEL_IDX_W-1:0] w_idx;

  assign w_is_p  = i_sel[SEL_BANK_BIT];
  assign w_idx   = i_sel[SEL_IDX_W-1:0];
  assign o_legal = w_is_p ? (int'(w_idx) < NUM_P) : (int'(w_idx) < NUM_G);

  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves one unassigned (no latch).
    o_g_in  = '0;
    o_g_out = '0;
    o_p_in  = '0;
    o_p_out = '0;
    for (int i = 0; i < NUM_G; i++) begin
      if (!w_is_p && int'(w_idx) == i) begin
        o_g_in[i]  = i_in_en;
        o_g_out[i] = i_out_en;
      end
    end
    for (int i = 0; i < NUM_P; i++) begin
      if (w_is_p && int'(w_idx) == i) begin
        o_p_in[i]  = i_in_en;
        o_p_out[i] = i_out_en;
      end
    end
  end

endmodule

// File: rtl/mem_access_fsm.sv
// Load/store sequencer: latches one memory instruction, walks the bus-transfer states,
// waits on MFC with a bounded timeout and reports completion or abort.
module mem_access_fsm
  import mem_access_fsm_pkg::*;
#(
  parameter int NUM_G   = 4,
  parameter int NUM_P   = 1,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input logic             clk,
  input logic             rst_n,
  mem_access_fsm_if.slave bus
);

  state_e           r_state;
  logic [15:0]      r_instr;
  logic [CNT_W-1:0] r_cnt;
  strobe_t          r_strb;
  logic [NUM_G-1:0] r_g_in, r_g_out;
  logic [NUM_P-1:0] r_p_in, r_p_out;

  state_e           w_state_nxt;
  logic [15:0]      w_instr_nxt;
  logic             w_is_store, w_postinc, w_legal;
  logic             w_data_in_en, w_data_out_en, w_addr_out_en;
  logic             w_data_legal, w_addr_legal;
  strobe_t          w_strb_nxt;
  logic [NUM_G-1:0] w_dg_in, w_dg_out, w_ag_in, w_ag_out;
  logic [NUM_P-1:0] w_dp_in, w_dp_out, w_ap_in, w_ap_out;

  // Outputs are registered from the next state, so the instruction they decode must
  // already be the one being accepted on the IDLE edge.
  assign w_instr_nxt = (r_state == S_IDLE && bus.start) ? bus.instr : r_instr;
  assign w_is_store  = field(w_instr_nxt, OPC_LSB) == OP_STORE;
  assign w_postinc   = field(w_instr_nxt, MODE_LSB) == MODE_POSTINC;
  assign w_legal     = (field(w_instr_nxt, OPC_LSB) == OP_LOAD || w_is_store)
                    && (field(w_instr_nxt, MODE_LSB) == MODE_PLAIN || w_postinc)
                    && w_data_legal && w_addr_legal;

  assign w_data_in_en  = (w_state_nxt == S_XFER);
  assign w_data_out_en = (w_state_nxt == S_DATA);
  assign w_addr_out_en = (w_state_nxt == S_ADDR);

  reg_sel_decode #(.NUM_G(NUM_G), .NUM_P(NUM_P)) u_data_sel (
    .i_sel    (field(w_instr_nxt, DSEL_LSB)),
    .i_in_en  (w_data_in_en),
    .i_out_en (w_data_out_en),
    .o_g_in   (w_dg_in),
    .o_g_out  (w_dg_out),
    .o_p_in   (w_dp_in),
    .o_p_out  (w_dp_out),
    .o_legal  (w_data_legal)
  );

  reg_sel_decode #(.NUM_G(NUM_G), .NUM_P(NUM_P)) u_addr_sel (
    .i_sel    (field(w_instr_nxt, ASEL_LSB)),
    .i_in_en  (1'b0),
    .i_out_en (w_addr_out_en),
    .o_g_in   (w_ag_in),
    .o_g_out  (w_ag_out),
    .o_p_in   (w_ap_in),
    .o_p_out  (w_ap_out),
    .o_legal  (w_addr_legal)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (bus.start) w_state_nxt = w_legal ? S_ADDR : S_ERR;
      S_ADDR:     w_state_nxt = w_is_store ? S_DATA : S_REQ;
      S_DATA:     w_state_nxt = S_REQ;
      S_REQ:      w_state_nxt = S_WAIT_MFC;
      S_WAIT_MFC: begin
        if (bus.MFC) begin
          if (!w_is_store)    w_state_nxt = S_READ;
          else if (w_postinc) w_state_nxt = S_INC;
          else                w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_ERR;
        end
      end
      S_READ:     w_state_nxt = S_XFER;
      S_XFER:     w_state_nxt = w_postinc ? S_INC : S_DONE;
      S_INC:      w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      S_ERR:      w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_strb_nxt      = '0;
    w_strb_nxt.busy = (w_state_nxt != S_IDLE);
    unique case (w_state_nxt)
      S_ADDR:            w_strb_nxt.mar_en       = 1'b1;
      S_DATA:            w_strb_nxt.mdr_en_write = 1'b1;
      S_REQ, S_WAIT_MFC: begin
        w_strb_nxt.mem_en = 1'b1;
        w_strb_nxt.mem_rw = w_is_store;
      end
      S_READ:            w_strb_nxt.mdr_en_read  = 1'b1;
      S_XFER:            w_strb_nxt.mdr_out      = 1'b1;
      S_INC:             w_strb_nxt.addr_inc     = 1'b1;
      S_DONE: begin
        w_strb_nxt.done   = 1'b1;
        w_strb_nxt.pc_inc = 1'b1;
      end
      S_ERR: begin
        w_strb_nxt.done   = 1'b1;
        w_strb_nxt.err    = 1'b1;
        w_strb_nxt.pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_cnt   <= '0;
      r_strb  <= '0;
      r_g_in  <= '0;
      r_g_out <= '0;
      r_p_in  <= '0;
      r_p_out <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && bus.start) r_instr <= bus.instr;
      if (r_state == S_REQ)                          r_cnt <= '0;
      else if (r_state == S_WAIT_MFC && !bus.MFC)    r_cnt <= r_cnt + 1'b1;
      r_strb  <= w_strb_nxt;
      r_g_in  <= w_dg_in  | w_ag_in;
      r_g_out <= w_dg_out | w_ag_out;
      r_p_in  <= w_dp_in  | w_ap_in;
      r_p_out <= w_dp_out | w_ap_out;
    end
  end

  assign bus.busy         = r_strb.busy;
  assign bus.PC_inc       = r_strb.pc_inc;
  assign bus.MAR_EN       = r_strb.mar_en;
  assign bus.mem_EN       = r_strb.mem_en;
  assign bus.mem_RW       = r_strb.mem_rw;
  assign bus.MDR_EN_read  = r_strb.mdr_en_read;
  assign bus.MDR_EN_write = r_strb.mdr_en_write;
  assign bus.MDR_out      = r_strb.mdr_out;
  assign bus.addr_inc     = r_strb.addr_inc;
  assign bus.done         = r_strb.done;
  assign bus.err          = r_strb.err;
  assign bus.G_in         = r_g_in;
  assign bus.G_out        = r_g_out;
  assign bus.P_in         = r_p_in;
  assign bus.P_out        = r_p_out;

endmodule

// File: tb/tb_mem_access_fsm.sv
// Directed bench for mem_access_fsm: per-cycle output vectors for each transaction are
// written out by hand and compared against a packed snapshot of every DUT output.
module tb_mem_access_fsm;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_fsm_if #(.NUM_G(4), .NUM_P(1)) bus ();

  mem_access_fsm #(.NUM_G(4), .NUM_P(1), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Snapshot layout: busy PC MAR mEN RW MDRr MDRw MDRo inc done err | G_in G_out | P_in P_out
  localparam logic [20:0] BUSY = 21'd1 << 20;
  localparam logic [20:0] PC   = 21'd1 << 19;
  localparam logic [20:0] MAR  = 21'd1 << 18;
  localparam logic [20:0] MEN  = 21'd1 << 17;
  localparam logic [20:0] RW   = 21'd1 << 16;
  localparam logic [20:0] MDRR = 21'd1 << 15;
  localparam logic [20:0] MDRW = 21'd1 << 14;
  localparam logic [20:0] MDRO = 21'd1 << 13;
  localparam logic [20:0] INC  = 21'd1 << 12;
  localparam logic [20:0] DONE = 21'd1 << 11;
  localparam logic [20:0] ERR  = 21'd1 << 10;
  localparam logic [20:0] PIN  = 21'd1 << 1;
  localparam logic [20:0] POUT = 21'd1;

  function automatic logic [20:0] gin(input int i);
    return 21'd1 << (6 + i);
  endfunction

  function automatic logic [20:0] gout(input int i);
    return 21'd1 << (2 + i);
  endfunction

  function automatic logic [20:0] snap();
    return {bus.busy, bus.PC_inc, bus.MAR_EN, bus.mem_EN, bus.mem_RW, bus.MDR_EN_read,
            bus.MDR_EN_write, bus.MDR_out, bus.addr_inc, bus.done, bus.err,
            bus.G_in, bus.G_out, bus.P_in, bus.P_out};
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  logic [20:0] exp_seq   [0:31];
  logic        mfc_seq   [0:31];
  logic        start_seq [0:31];

  task automatic clear_tables();
    for (int k = 0; k < 32; k++) begin
      exp_seq[k]   = '0;
      mfc_seq[k]   = 1'b0;
      start_seq[k] = 1'b0;
    end
  endtask

  // Called #1 after a rising edge in an IDLE cycle; checks cycles 1..n after the start edge.
  // A start raised mid-transaction carries an illegal instruction that must be ignored.
  task automatic run(input string tag, input logic [15:0] ins, input int n);
    bus.instr = ins;
    bus.start = 1'b1;
    bus.MFC   = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= n; k++) begin
      bus.start = start_seq[k];
      bus.instr = start_seq[k] ? 16'h7000 : ins;
      bus.MFC   = mfc_seq[k];
      check($sformatf("%s c%0d", tag, k), 32'(snap()), 32'(exp_seq[k]));
      if (k < n) begin
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    bus.MFC   = 1'b0;
  endtask

  task automatic load_4081_table();
    clear_tables();
    exp_seq[1] = BUSY | MAR | gout(1);
    exp_seq[2] = BUSY | MEN;
    exp_seq[3] = BUSY | MEN;
    exp_seq[4] = BUSY | MEN;
    exp_seq[5] = BUSY | MEN;  mfc_seq[5] = 1'b1;
    exp_seq[6] = BUSY | MDRR;
    exp_seq[7] = BUSY | MDRO | PIN;
    exp_seq[8] = BUSY | DONE | PC;
    exp_seq[9] = '0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.instr = '0;
    bus.MFC   = 1'b0;

    #2 check("reset_outputs", 32'(snap()), 32'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 32'(snap()), 32'h0);

    // LOAD P0 <- (G1), MFC after two empty WAIT cycles
    load_4081_table();
    run("load_g1_p0", 16'h4081, 9);

    // STORE G2 -> (G3), MFC on first WAIT; illegal starts mid-flight must be ignored
    clear_tables();
    exp_seq[1] = BUSY | MAR | gout(3);   start_seq[1] = 1'b1;
    exp_seq[2] = BUSY | MDRW | gout(2);  start_seq[2] = 1'b1;
    exp_seq[3] = BUSY | MEN | RW;        start_seq[3] = 1'b1;
    exp_seq[4] = BUSY | MEN | RW;        mfc_seq[4]   = 1'b1;
    exp_seq[5] = BUSY | DONE | PC;
    exp_seq[6] = '0;
    run("store_g2_g3", 16'h5023, 6);

    // Post-increment LOAD G1 <- (G0)
    clear_tables();
    exp_seq[1] = BUSY | MAR | gout(0);
    exp_seq[2] = BUSY | MEN;
    exp_seq[3] = BUSY | MEN;             mfc_seq[3] = 1'b1;
    exp_seq[4] = BUSY | MDRR;
    exp_seq[5] = BUSY | MDRO | gin(1);
    exp_seq[6] = BUSY | INC;
    exp_seq[7] = BUSY | DONE | PC;
    exp_seq[8] = '0;
    run("load_postinc", 16'h4110, 8);

    // Post-increment STORE P0 -> (G0); MFC outside WAIT is ignored
    clear_tables();
    exp_seq[1] = BUSY | MAR | gout(0);   mfc_seq[1] = 1'b1;
    exp_seq[2] = BUSY | MDRW | POUT;     mfc_seq[2] = 1'b1;
    exp_seq[3] = BUSY | MEN | RW;        mfc_seq[3] = 1'b1;
    exp_seq[4] = BUSY | MEN | RW;
    exp_seq[5] = BUSY | MEN | RW;        mfc_seq[5] = 1'b1;
    exp_seq[6] = BUSY | INC;
    exp_seq[7] = BUSY | DONE | PC;
    exp_seq[8] = '0;
    run("store_postinc", 16'h5180, 8);

    // Timeout: WAIT entered in cycle 3, ERR exactly 15 cycles later, no register load
    clear_tables();
    exp_seq[1] = BUSY | MAR | gout(1);
    exp_seq[2] = BUSY | MEN;
    for (int k = 3; k <= 17; k++) exp_seq[k] = BUSY | MEN;
    exp_seq[18] = BUSY | DONE | ERR | PC;
    exp_seq[19] = '0;
    run("timeout", 16'h4081, 19);

    // Illegal opcode, illegal select (P1) and illegal mode go straight to ERR
    clear_tables();
    exp_seq[1] = BUSY | DONE | ERR | PC;
    exp_seq[2] = '0;
    run("illegal_opcode", 16'h7000, 2);
    run("illegal_sel_p1", 16'h4091, 2);
    run("illegal_mode", 16'h4201, 2);

    // Asynchronous reset while waiting on MFC, then a normal LOAD
    load_4081_table();
    run("pre_reset", 16'h4081, 3);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'(snap()), 32'h0);
    @(posedge clk); #1;
    check("held_reset_outputs", 32'(snap()), 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_rerelease", 32'(snap()), 32'h0);
    load_4081_table();
    run("load_after_reset", 16'h4081, 9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_fsm.md
# mem_access_fsm

Parametrised load/store sequencer for the microcontroller datapath. It accepts one 16-bit memory instruction per handshake and drives the bus-transfer enables, MAR/MDR strobes and one-hot register select lines. It then waits on the memory-function-complete (MFC) handshake with a bounded timeout. It is the generalised successor of the fixed G0–G3/P0 load FSM: register counts are parametrised, and it adds store, post-increment addressing and error reporting.

## Interface
- NUM_G, default 4: general registers G0..G(NUM_G-1); range 1..8
- NUM_P, default 1: port registers P0..P(NUM_P-1); range 1..8
- TIMEOUT, default 15: maximum cycles spent in WAIT_MFC before abort; ≥1
- CNT_W, default $clog2(TIMEOUT+1): timeout counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  instruction valid; sampled only in IDLE
- instr  in  16  [15:12] opcode, [11:8] mode, [7:4] data reg sel, [3:0] address reg sel
- MFC  in  1  memory function complete
- busy  out  1  high in every state except IDLE
- PC_inc, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_EN_write, MDR_out  out  1 each  datapath strobes; mem_RW 1 = write
- addr_inc  out  1  increment the selected address register (post-increment mode)
- G_in, G_out  out  NUM_G  one-hot general register load/drive
- P_in, P_out  out  NUM_P  one-hot port register load/drive
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done on abort

## Operation
- Register select encoding: bit3 = 0 selects G[sel[2:0]]; bit3 = 1 selects P[sel[2:0]]. An index ≥ NUM_G or ≥ NUM_P is illegal.
- Opcodes: 4'h4 LOAD, 4'h5 STORE. mode 4'h0 is plain; mode 4'h1 is post-increment. Any other opcode or mode, or any illegal select, is illegal.
- The instruction is latched on start in IDLE and held until the FSM returns to IDLE.
- States: IDLE, ADDR, DATA, REQ, WAIT_MFC, READ, XFER, INC, DONE, ERR.
- LOAD path: IDLE → ADDR → REQ → WAIT_MFC → READ → XFER → [INC] → DONE → IDLE.
- STORE path: IDLE → ADDR → DATA → REQ → WAIT_MFC → [INC] → DONE → IDLE.
- Outputs are Moore-decoded from the state and the latched instruction:
  - ADDR: addr-reg _out, MAR_EN
  - DATA: data-reg _out, MDR_EN_write
  - REQ and WAIT_MFC: mem_EN; mem_RW = store
  - READ: MDR_EN_read
  - XFER: MDR_out, data-reg _in
  - INC: addr_inc
  - DONE: done, PC_inc
  - ERR: done, err, PC_inc
- At most one _out line across G_out/P_out/MDR_out is high in any cycle.
- An illegal instruction goes IDLE → ERR directly. No bus strobe is asserted.
- WAIT_MFC counter: cleared on entry and incremented each cycle while MFC = 0.
  - MFC = 1 in any WAIT_MFC cycle, including the first, exits next edge.
  - If the count reaches TIMEOUT with MFC = 0, the FSM goes to ERR with no register write and no INC.
- MFC outside WAIT_MFC is ignored. start outside IDLE is ignored.

## Timing
- Reset: state = IDLE, counter = 0, latched instruction = 0. Every output is 0, including busy, mem_RW, and all select vectors.
- Reset mid-operation aborts immediately. No done or err pulse is produced.
- Latency with MFC present on the first WAIT cycle, from the start-sampling edge to the DONE cycle:
  - LOAD: 6 cycles
  - STORE: 5 cycles
  - post-increment: +1 cycle
- Each extra MFC wait cycle adds 1.
- Timeout: ERR is entered TIMEOUT cycles after entering WAIT_MFC.
- done is high for exactly one cycle. A new start is accepted on the IDLE cycle immediately after DONE or ERR.
- mem_EN is continuous from REQ through the last WAIT_MFC cycle. mem_RW is stable during that whole window.

## Structure
- A shared package holds:
  - opcode/mode constants (OP_LOAD, OP_STORE, MODE_PLAIN, MODE_POSTINC)
  - the state enum
  - select-field bit positions
- Sub-module reg_sel_decode: converts the 4-bit select plus in/out enables into the G_in/G_out/P_in/P_out one-hot vectors, with a legal flag. It is instantiated twice, once for the data field and once for the address field.

## Test plan
- LOAD (G1), P0 (instr 16'h4081), MFC high for 1 cycle after 2 WAIT cycles:
  - states traverse ADDR/REQ/WAIT×3/READ/XFER/DONE
  - G_out = 4'b0010 with MAR_EN
  - P_in = 1'b1 with MDR_out
  - done and PC_inc pulse once
- STORE G2 → (G3) (instr 16'h5023), MFC on first WAIT cycle:
  - G_out = 4'b0100 with MDR_EN_write before mem_EN
  - mem_RW = 1 throughout REQ/WAIT
  - done at cycle 5
- Post-increment LOAD (instr 16'h4110): addr_inc pulses for exactly one cycle, between XFER and DONE.
- MFC never asserted, TIMEOUT = 15:
  - ERR entered 15 cycles after entering WAIT_MFC
  - err and done pulse together
  - no _in line asserted
- Illegal opcode 16'h7000 and illegal select 16'h4091 (P1 with NUM_P = 1): ERR on the next edge, zero bus strobes.
- rst low during WAIT_MFC: all outputs are 0 asynchronously. After release, a start with 16'h4081 completes normally.
